// File: rtl/adder_seq_ctrl_pkg.sv
// Shared helpers for the nibble-serial adder sequencer.
package adder_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    // Index register needs at least one bit even when only one slice exists.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_adder4.sv
// Combinational 4-bit ripple-carry adder slice.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer that adds two WIDTH-bit operands one nibble per clock through a
// single shared adder4 slice, LSB nibble first, with start/busy/done handshake.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = idx_width(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg, cout_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [3:0] a_nib [NSLICE];
    logic [3:0] b_nib [NSLICE];
    logic [3:0] slice_a, slice_b, slice_sum;
    logic       slice_cout;
    logic       last_slice;

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[SLICE_W*gi +: SLICE_W];
            assign b_nib[gi] = b_reg[SLICE_W*gi +: SLICE_W];
        end
    endgenerate

    assign slice_a    = a_nib[idx_reg];
    assign slice_b    = b_nib[idx_reg];
    assign last_slice = (idx_reg == IDX_W'(NSLICE - 1));

    adder4 u_adder4 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured once so the producer may change a/b/cin mid-add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_reg[SLICE_W*idx_reg +: SLICE_W] <= slice_sum;
                    carry_reg <= slice_cout;
                    if (last_slice) begin
                        cout_reg <= slice_cout;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: idx_reg <= '0;
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == RUN) || (state_reg == DONE);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl at WIDTH=16: vector table, random adds
// against an arithmetic reference, and hand-written handshake corner cases.
module tb_adder_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    adder_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // One add: start pulsed for one edge, inputs scrambled after accept,
    // result, latency and pulse width checked against the expected values.
    task automatic run_check(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic tc, input logic [W-1:0] es, input logic ec);
        int lat;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'd5);
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
        $display("%s: a=0x%04h b=0x%04h cin=%0d -> sum=0x%04h cout=%0d (lat %0d)",
                 name, ta, tb, tc, sum, cout, lat);
        @(negedge clk);
        chk({name, "_pulse"}, 32'(done), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_held"}, 32'({cout, sum}), 32'({ec, es}));
    endtask

    vec_t       vecs [6];
    logic [W:0] r;
    logic [W:0] q [$];

    initial begin
        int d0, lat, cyc, acc, ndone, last_done;
        logic [W-1:0] ca, cb;
        logic cc, prev_busy;
        logic [W:0] e;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec);

        for (int i = 0; i < 20; i++) begin
            ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
            r = ref_add(ca, cb, cc);
            run_check($sformatf("rand%0d", i), ca, cb, cc, r[W-1:0], r[W]);
        end

        // Busy rejection in RUN and DONE
        d0 = done_cnt;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("busyrej_done", 32'(done), 32'd1);
        chk("busyrej_sum", 32'(sum), 32'h0002);
        chk("busyrej_cout", 32'(cout), 32'd0);
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busyrej_idle", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        chk("busyrej_pulses", 32'(done_cnt - d0), 32'd1);
        chk("busyrej_still_idle", 32'(busy), 32'd0);
        chk("busyrej_held", 32'(sum), 32'h0002);
        $display("busy_rejection: sum=0x%04h pulses=%0d", sum, done_cnt - d0);

        // Reset two cycles into RUN
        d0 = done_cnt;
        @(negedge clk);
        a = 16'h7777; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        $display("reset_mid_op: busy=%0d sum=0x%04h", busy, sum);
        run_check("post_rst", 16'h7777, 16'h1111, 1'b1, 16'h8889, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
        a = ca; b = cb; cin = cc; start = 1'b1;
        prev_busy = busy;
        cyc = 0; acc = 0; ndone = 0; last_done = -1;
        while (ndone < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
                q.push_back(ref_add(ca, cb, cc));
                acc++;
                if (acc >= 5) start = 1'b0;
                ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
                a = ca; b = cb; cin = cc;
            end
            prev_busy = busy;
            if (done) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                chk($sformatf("b2b%0d_result", ndone), 32'({cout, sum}), 32'(e));
                if (last_done >= 0)
                    chk($sformatf("b2b%0d_spacing", ndone), 32'(cyc - last_done), 32'd6);
                $display("back_to_back %0d: sum=0x%04h cout=%0d at cycle %0d", ndone, sum, cout, cyc);
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
